axi_wid_tracker: RTL

- AXI4-to-AXI3 write-channel adapter between the CPU core's AXI4 master port and the AXI3 SoC interconnect.
- Records the ID and burst length of every accepted AW transaction in an in-order FIFO. Drives AXI3 wid from the FIFO head and regenerates wlast from a beat counter.
- Allows up to DEPTH outstanding write bursts, so W data can lag AW by several transactions.

---
 rtl/axi_wid_tracker_if.sv | 35 +++
 rtl/axi_wid_tracker.sv | 91 +++++++++
 2 files changed

// File: rtl/axi_wid_tracker_if.sv
// AXI4 core side plus AXI3 interconnect side write-address/write-data signals for axi_wid_tracker.
// slave: the adapter's view. master: the view of the agent that drives the core and interconnect.
interface axi_wid_tracker_if #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic                s_awvalid, s_awready;
  logic [ID_W-1:0]     s_awid;
  logic [LEN_W-1:0]    s_awlen;
  logic                m_awvalid, m_awready;
  logic [ID_W-1:0]     m_awid;
  logic [LEN_W-1:0]    m_awlen;
  logic                s_wvalid, s_wready, s_wlast;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                m_wvalid, m_wready, m_wlast;
  logic [ID_W-1:0]     m_wid;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;

  modport slave (
    input  s_awvalid, s_awid, s_awlen, m_awready,
           s_wvalid, s_wdata, s_wstrb, s_wlast, m_wready,
    output s_awready, m_awvalid, m_awid, m_awlen,
           s_wready, m_wvalid, m_wid, m_wdata, m_wstrb, m_wlast
  );

  modport master (
    output s_awvalid, s_awid, s_awlen, m_awready,
           s_wvalid, s_wdata, s_wstrb, s_wlast, m_wready,
    input  s_awready, m_awvalid, m_awid, m_awlen,
           s_wready, m_wvalid, m_wid, m_wdata, m_wstrb, m_wlast
  );
endinterface

// File: rtl/axi_wid_tracker.sv
// AXI4->AXI3 write adapter: queues {awid, awlen} per accepted AW, drives wid from the head and regenerates wlast.
// Optional macro AXI_WID_BYPASS_EN lets W pass in the same cycle as AW while the queue is empty.
module axi_wid_tracker #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axi_wid_tracker_if.slave       bus,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   wlast_err
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } ent_t;

  ent_t             fifo [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic [LEN_W-1:0] beat_cnt;
  logic [ID_W-1:0]  last_id;
  ent_t             head;
  logic             empty, full, aw_ok, aw_hs, w_hs, push, pop, byp;

  assign head  = fifo[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign aw_ok = aresetn & ~full;

  assign bus.m_awvalid = bus.s_awvalid & aw_ok;
  assign bus.s_awready = bus.m_awready & aw_ok;
  assign bus.m_awid    = bus.s_awid;
  assign bus.m_awlen   = bus.s_awlen;
  assign bus.m_wdata   = bus.s_wdata;
  assign bus.m_wstrb   = bus.s_wstrb;

  // With the queue empty, m_wid falls back to the last completed burst's id so it never goes X.
  always_comb begin
    byp          = 1'b0;
    bus.m_wvalid = aresetn & bus.s_wvalid & ~empty;
    bus.s_wready = aresetn & bus.m_wready & ~empty;
    bus.m_wid    = !aresetn ? '0 : (empty ? last_id : head.id);
    bus.m_wlast  = aresetn & ~empty & (beat_cnt == head.len);
`ifdef AXI_WID_BYPASS_EN
    if (aresetn && empty && bus.s_awvalid) begin
      byp          = 1'b1;
      bus.m_wvalid = bus.s_wvalid & bus.s_awvalid;
      bus.s_wready = bus.m_wready & bus.m_awready;
      bus.m_wid    = bus.s_awid;
      bus.m_wlast  = (bus.s_awlen == '0);
    end
`endif
  end

  assign aw_hs = bus.s_awvalid & bus.s_awready;
  assign w_hs  = bus.s_wvalid & bus.s_wready;
  assign pop   = w_hs & bus.m_wlast & ~byp;
  // A bypassed single-beat burst finishes in its AW cycle and never needs an entry.
  assign push  = aw_hs & ~(byp & w_hs & bus.m_wlast);

  always_ff @(posedge aclk)
    if (push) fifo[wptr[AW-1:0]] <= '{id: bus.s_awid, len: bus.s_awlen};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wptr      <= '0;
      rptr      <= '0;
      beat_cnt  <= '0;
      last_id   <= '0;
      wlast_err <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (w_hs) begin
        if (bus.m_wlast) begin
          beat_cnt <= '0;
          last_id  <= bus.m_wid;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        if (bus.s_wlast != bus.m_wlast) wlast_err <= 1'b1;
      end
    end
  end

  assign outstanding = aresetn ? (wptr - rptr) : '0;
endmodule
